bram_writer: RTL and testbench
==============================

BRAM_WRITER -- requirements
Module: bram_writer

Interface
REQ-001 Parameter W, default 128, meaning frame width in pixels.
REQ-002 Parameter H, default 128, meaning frame height in pixels.
REQ-003 Parameter DW, default 16, meaning pixel width (RGB565).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 s_valid  in  1  input pixel valid.
REQ-007 s_ready  out  1  input pixel ready; transfer when s_valid && s_ready.
REQ-008 s_data  in  DW  input pixel.
REQ-009 s_sof  in  1  marks the first pixel of a frame; qualified by s_valid.
REQ-010 clr_req  in  1  request to fill the whole buffer with clr_color.
REQ-011 clr_color  in  DW  fill value, sampled each CLEAR write cycle.
REQ-012 busy  out  1  high while in CLEAR.
REQ-013 frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
REQ-014 err_sof  out  1  one-cycle pulse on s_sof received mid-frame.
REQ-015 wr_en  out  1  BRAM write-port enable.
REQ-016 wr_addr  out  log2(W*H)  BRAM write address, 14 bits at defaults.
REQ-017 wr_data  out  DW  BRAM write data.

Function
REQ-018 The FSM SHALL have states IDLE, FILL and CLEAR.
REQ-019 Addresses SHALL be computed as row*W + col; col wraps at W-1 to 0 and increments row; row wraps at H-1.
REQ-020 s_ready SHALL equal (state != CLEAR) && !clr_req, combinationally.
REQ-021 In IDLE, an accepted pixel without s_sof SHALL be dropped with no write.
REQ-022 In IDLE, an accepted pixel with s_sof SHALL be written to address 0; the FSM then enters FILL with the next address at 1.
REQ-023 In FILL, each accepted pixel SHALL be written at the current address, and the address SHALL then advance by one.
REQ-024 Write latency SHALL be 1 cycle: a pixel accepted in cycle N drives wr_en=1, wr_addr and wr_data (all registered) in cycle N+1.
REQ-025 wr_en SHALL be 0 in every cycle that has no accepted or clear write in the previous cycle.
REQ-026 Acceptance of the pixel at row H-1, col W-1 SHALL return the FSM to IDLE.
REQ-027 frame_done SHALL pulse in the same cycle as that pixel's write.
REQ-028 s_sof accepted in FILL SHALL restart the frame: the pixel is written to address 0, err_sof pulses in the write cycle, and the FSM stays in FILL.
REQ-029 clr_req high in IDLE or FILL SHALL abort any frame in progress and enter CLEAR next cycle, with no frame_done.
REQ-030 In the cycle clr_req is high, no pixel SHALL be accepted.
REQ-031 CLEAR SHALL write clr_color to addresses 0..W*H-1, one per cycle, ascending.
REQ-032 CLEAR SHALL last exactly W*H cycles, then go to IDLE with the address counter at 0.
REQ-033 clr_req asserted during CLEAR SHALL be ignored.
REQ-034 Pixel gaps (s_valid low) SHALL stall the address counter without penalty.

Reset
REQ-035 reset SHALL force IDLE, row=col=0, and wr_en, frame_done, err_sof and busy = 0.
REQ-036 reset SHALL force wr_addr and wr_data to 0.
REQ-037 reset mid-FILL or mid-CLEAR SHALL discard the operation, with no further writes from the next cycle.

Configuration
REQ-038 With macro BRAM_WRITER_CLEAR_EN defined, CLEAR, clr_req, clr_color and busy SHALL behave as above.
REQ-039 Without BRAM_WRITER_CLEAR_EN, the CLEAR state SHALL be absent, clr_req and clr_color ignored, busy tied 0, and s_ready = 1 at all times.

Structure
REQ-040 A shared package bram_pkg SHALL hold W, H, DW, ADDR_W = log2(W*H) and the state enum type.
REQ-041 Row/col wrap counting SHALL live in sub-module bram_addr_counter (inputs: inc, clr; outputs: row, col, addr, last).

Verification
REQ-042 Full frame: 16384 pixels, first with s_sof, data = index -> wr_addr 0..16383 with wr_data = index, one frame_done coincident with addr 16383.
REQ-043 Pre-sof garbage: 5 pixels without s_sof, then a frame -> no writes before the sof pixel; first write is addr 0.
REQ-044 Mid-frame resync: s_sof at pixel 200 -> err_sof pulse, that pixel written to addr 0, frame_done only after 16384 further pixels.
REQ-045 Clear: clr_req at pixel 50 with clr_color 16'h0F00 -> s_ready=0, busy=1 for 16384 cycles, writes addr 0..16383 = 16'h0F00, no frame_done.
REQ-046 Throttled input: s_valid random 50% during a frame -> write count and addresses identical to the REQ-042 frame, wr_en only 1 cycle after each transfer.
REQ-047 Reset in FILL at pixel 1000 -> wr_en=0 next cycle; the next sof frame starts at addr 0.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared frame geometry and FSM state type for the BRAM frame writer.
// Optional CLEAR state is present only with BRAM_WRITER_CLEAR_EN.
package bram_pkg;
    localparam int W      = 128;
    localparam int H      = 128;
    localparam int DW     = 16;
    localparam int ADDR_W = $clog2(W * H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1
`ifdef BRAM_WRITER_CLEAR_EN
        ,
        CLEAR = 2'd2
`endif
    } state_t;
endpackage

// File: rtl/bram_addr_counter.sv
// Row/column raster counter producing the linear BRAM address row*W + col.
// clr together with inc lands on position 1 (restart after writing address 0).
module bram_addr_counter #(
    parameter int W  = bram_pkg::W,
    parameter int H  = bram_pkg::H,
    parameter int AW = $clog2(W * H),
    parameter int CW = (W > 1) ? $clog2(W) : 1,
    parameter int RW = (H > 1) ? $clog2(H) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [AW-1:0] addr,
    output logic          last
);
    logic [CW-1:0] col_b;
    logic [RW-1:0] row_b;

    always_comb begin
        col_b = clr ? '0 : col;
        row_b = clr ? '0 : row;
    end

    assign last = (row == RW'(H - 1)) && (col == CW'(W - 1));
    assign addr = AW'(int'(row) * W + int'(col));

    always_ff @(posedge clk) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col_b == CW'(W - 1)) begin
                col <= '0;
                row <= (row_b == RW'(H - 1)) ? '0 : row_b + 1'b1;
            end else begin
                col <= col_b + 1'b1;
                row <= row_b;
            end
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end
    end
endmodule

// File: rtl/bram_writer.sv
// Streams frame pixels into a BRAM write port with sof sync and optional
// full-buffer clear (enabled by defining BRAM_WRITER_CLEAR_EN).
module bram_writer #(
    parameter int W  = bram_pkg::W,
    parameter int H  = bram_pkg::H,
    parameter int DW = bram_pkg::DW,
    localparam int AW = $clog2(W * H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_sof,
    input  logic          clr_req,
    input  logic [DW-1:0] clr_color,
    output logic          busy,
    output logic          frame_done,
    output logic          err_sof,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);
    import bram_pkg::*;

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    state_t        state, state_n;
    logic          accept, clr_go;
    logic          inc, clr_cnt, last;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [AW-1:0] addr;
    logic          wen_d, done_d, err_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] data_d;
    logic          unused_rc;

    assign unused_rc = ^{row, col};

`ifdef BRAM_WRITER_CLEAR_EN
    assign clr_go  = clr_req && (state != CLEAR);
    assign busy    = (state == CLEAR);
    assign s_ready = (state != CLEAR) && !clr_req;
`else
    logic unused_clr;
    assign unused_clr = ^{clr_req, clr_color};
    assign clr_go  = 1'b0;
    assign busy    = 1'b0;
    assign s_ready = 1'b1;
`endif

    assign accept = s_valid && s_ready;

    bram_addr_counter #(
        .W (W),
        .H (H),
        .AW(AW),
        .CW(CW),
        .RW(RW)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (inc),
        .clr  (clr_cnt),
        .row  (row),
        .col  (col),
        .addr (addr),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
`ifdef BRAM_WRITER_CLEAR_EN
                if (clr_go) state_n = CLEAR;
                else
`endif
                if (accept && s_sof) state_n = FILL;
            end
            FILL: begin
`ifdef BRAM_WRITER_CLEAR_EN
                if (clr_go) state_n = CLEAR;
                else
`endif
                if (accept && !s_sof && last) state_n = IDLE;
            end
`ifdef BRAM_WRITER_CLEAR_EN
            CLEAR: begin
                if (last) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        wen_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr;
        data_d  = s_data;
        inc     = 1'b0;
        clr_cnt = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_go) begin
                    clr_cnt = 1'b1;
                end else if (accept && s_sof) begin
                    wen_d   = 1'b1;
                    addr_d  = '0;
                    clr_cnt = 1'b1;
                    inc     = 1'b1;
                end
            end
            FILL: begin
                if (clr_go) begin
                    clr_cnt = 1'b1;
                end else if (accept) begin
                    wen_d = 1'b1;
                    inc   = 1'b1;
                    if (s_sof) begin
                        // resync: restart the raster at address 0
                        addr_d  = '0;
                        err_d   = 1'b1;
                        clr_cnt = 1'b1;
                    end else begin
                        done_d = last;
                    end
                end
            end
`ifdef BRAM_WRITER_CLEAR_EN
            CLEAR: begin
                wen_d  = 1'b1;
                data_d = clr_color;
                inc    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en      <= wen_d;
            frame_done <= done_d;
            err_sof    <= err_d;
            if (wen_d) begin
                wr_addr <= addr_d;
                wr_data <= data_d;
            end
        end
    end
endmodule

// File: tb/tb_bram_writer.sv
// Randomized bench for bram_writer against a frame-position reference model.
// Exercises the clear path when BRAM_WRITER_CLEAR_EN is defined.
module tb_bram_writer;
    import bram_pkg::*;

    localparam int N  = W * H;
    localparam int AW = ADDR_W;
`ifdef BRAM_WRITER_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, s_valid, s_ready, s_sof, clr_req;
    logic [DW-1:0] s_data, clr_color, wr_data;
    logic          busy, frame_done, err_sof, wr_en;
    logic [AW-1:0] wr_addr;

    always #5 clk = ~clk;

    bram_writer #(.W(W), .H(H), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .clr_req   (clr_req),
        .clr_color (clr_color),
        .busy      (busy),
        .frame_done(frame_done),
        .err_sof   (err_sof),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position inside the current frame, clear progress,
    // and the write expected one cycle after each edge.
    int            pos = 0;
    bit            infr = 0;
    bit            cmode = 0;
    int            ccnt = 0;
    logic          e_en = 0, e_done = 0, e_err = 0;
    int            e_addr = 0;
    logic [DW-1:0] e_data = '0;
    bit            chk_on = 0;

    always @(posedge clk) begin
        e_en   = 0;
        e_done = 0;
        e_err  = 0;
        if (reset) begin
            pos = 0; infr = 0; cmode = 0; ccnt = 0;
        end else if (cmode) begin
            e_en   = 1;
            e_addr = ccnt;
            e_data = clr_color;
            ccnt++;
            if (ccnt == N) cmode = 0;
        end else if (CLR_EN && clr_req) begin
            cmode = 1; ccnt = 0; infr = 0;
        end else if (s_valid) begin
            if (s_sof) begin
                e_en = 1; e_addr = 0; e_data = s_data;
                e_err = infr; infr = 1; pos = 1;
            end else if (infr) begin
                e_en = 1; e_addr = pos; e_data = s_data;
                e_done = (pos == N - 1);
                pos++;
                if (e_done) infr = 0;
            end
        end
    end

    int wr_cnt, done_cnt, err_cnt, busy_cnt;
    int first_addr, last_addr, done_addr;

    task automatic clr_cnts();
        wr_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        first_addr = -1; last_addr = -1; done_addr = -1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("wr_en", wr_en, e_en);
            check("frame_done", frame_done, e_done);
            check("err_sof", err_sof, e_err);
            check("busy", busy, cmode);
            check("s_ready", s_ready, !cmode && !(CLR_EN && clr_req));
            if (e_en) begin
                check("wr_addr", wr_addr, e_addr);
                check("wr_data", wr_data, e_data);
            end
            if (wr_en === 1'b1) begin
                if (wr_cnt == 0) first_addr = wr_addr;
                last_addr = wr_addr;
                wr_cnt++;
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                done_addr = wr_addr;
            end
            if (err_sof === 1'b1) err_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
    end

    task automatic idle(input int n);
        s_valid = 0;
        s_sof   = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_px(input logic [DW-1:0] d, input logic sof,
                           input bit thr);
        if (thr) begin
            while ($urandom_range(0, 1) == 1) begin
                s_valid = 0;
                s_data  = DW'($urandom);
                s_sof   = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1;
        s_data  = d;
        s_sof   = sof;
        @(posedge clk);
        #1;
        s_valid = 0;
        s_sof   = 0;
    endtask

    initial begin
        reset = 1; s_valid = 0; s_sof = 0; s_data = '0;
        clr_req = 0; clr_color = 16'h0F00;
        clr_cnts();
        @(posedge clk);
        #1 chk_on = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err_sof", err_sof, 0);
        @(posedge clk);
        #1 reset = 0;

        // pre-sof garbage then a full indexed frame
        clr_cnts();
        for (int i = 0; i < 5; i++) send_px(DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < N; i++) send_px(DW'(i), i == 0, 1'b0);
        idle(4);
        check("t1_writes", wr_cnt, N);
        check("t1_first_addr", first_addr, 0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_addr", done_addr, N - 1);
        check("t1_err_cnt", err_cnt, 0);

        // mid-frame resync at pixel 200
        clr_cnts();
        for (int i = 0; i < 200; i++) send_px(DW'($urandom), i == 0, 1'b0);
        send_px(DW'($urandom), 1'b1, 1'b0);
        for (int i = 1; i < N; i++) send_px(DW'($urandom), 1'b0, 1'b0);
        idle(4);
        check("t2_writes", wr_cnt, 200 + N);
        check("t2_err_cnt", err_cnt, 1);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_done_addr", done_addr, N - 1);

        // throttled frame
        clr_cnts();
        for (int i = 0; i < N; i++) send_px(DW'($urandom), i == 0, 1'b1);
        idle(4);
        check("t3_writes", wr_cnt, N);
        check("t3_first_addr", first_addr, 0);
        check("t3_last_addr", last_addr, N - 1);
        check("t3_done_cnt", done_cnt, 1);

        // reset while filling, at pixel 1000
        clr_cnts();
        for (int i = 0; i < 1000; i++) send_px(DW'($urandom), i == 0, 1'b0);
        s_valid = 1;
        s_data  = DW'($urandom);
        reset   = 1;
        @(posedge clk);
        @(negedge clk);
        check("t4_wr_en_after_rst", wr_en, 0);
        check("t4_writes", wr_cnt, 1000);
        @(posedge clk);
        #1 reset = 0;
        s_valid = 0;
        clr_cnts();
        for (int i = 0; i < 10; i++) send_px(DW'($urandom), i == 0, 1'b0);
        idle(3);
        check("t4_restart_first", first_addr, 0);
        check("t4_restart_writes", wr_cnt, 10);
        check("t4_restart_done", done_cnt, 0);

`ifdef BRAM_WRITER_CLEAR_EN
        // clear request at pixel 50 of a frame
        for (int i = 0; i < 50; i++) send_px(DW'($urandom), i == 0, 1'b0);
        s_valid   = 1;
        s_sof     = 0;
        s_data    = DW'($urandom);
        clr_req   = 1;
        clr_color = 16'h0F00;
        @(negedge clk);
        check("t5_ready_on_req", s_ready, 0);
        @(posedge clk);
        #1;
        clr_cnts();
        for (int k = 0; k < N + 6; k++) begin
            clr_req = (k < N - 10) ? 1'($urandom) : 1'b0;
            s_valid = (k < 100);
            s_sof   = 1'($urandom);
            s_data  = DW'($urandom);
            @(posedge clk);
            #1;
        end
        s_valid = 0;
        s_sof   = 0;
        idle(2);
        check("t5_busy_cycles", busy_cnt, N);
        check("t5_writes", wr_cnt, N);
        check("t5_first_addr", first_addr, 0);
        check("t5_last_addr", last_addr, N - 1);
        check("t5_done_cnt", done_cnt, 0);
`else
        // without the clear feature clr_req must be ignored
        clr_cnts();
        clr_req = 1;
        s_valid = 1;
        s_sof   = 1;
        s_data  = DW'($urandom);
        @(negedge clk);
        check("noclr_ready", s_ready, 1);
        check("noclr_busy", busy, 0);
        @(posedge clk);
        #1;
        s_valid = 0;
        s_sof   = 0;
        idle(3);
        clr_req = 0;
        check("noclr_writes", wr_cnt, 1);
        check("noclr_first_addr", first_addr, 0);
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
